pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; successor to the fixed-field decode/execute register.
- Sits between any two CPU pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Carries one opaque control bundle and one opaque data bundle per instruction.
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush to a zero-control bubble, and asynchronous reset.

Parameters:
- DATA_W, 128: width of the data bundle (operands, immediate, PC+4, register indices).
- CTRL_W, 16: width of the control bundle (regwrite, memwrite, ALU control, ...); all-zero means no-op.
- CNT_W, 16: width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  register can accept; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held entries (branch mispredict, hazard bubble).
- out_valid  out  1  main entry holds a live instruction.
- out_ready  in  1  downstream stage accepts (low = stall).
- out_ctrl  out  CTRL_W  registered control; forced 0 whenever out_valid=0.
- out_data  out  DATA_W  registered data; forced 0 whenever out_valid=0.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, in_ready=1, state EMPTY. Release takes effect at the next clk edge.
- Transfers: in-xfer = in_valid & in_ready; out-xfer = out_valid & out_ready; both sampled at the rising edge.
- Latency: 1 cycle from in-xfer to out_valid when EMPTY. Full throughput of 1/cycle in steady state.
- State EMPTY (main invalid, skid invalid):
  - in-xfer -> ONE; main <= in.
- State ONE (main valid, skid invalid):
  - in-xfer & out-xfer -> ONE; main <= in.
  - in-xfer only -> TWO; skid <= in; main holds.
  - out-xfer only -> EMPTY; main ctrl/data <= 0.
  - neither -> hold.
- State TWO (both valid): in_ready=0.
  - out-xfer -> ONE; main <= skid; skid cleared.
  - otherwise -> hold.
- Ordering: output order always equals acceptance order; no entry is ever dropped or duplicated except by flush.
- Flush (highest priority after reset): at the edge where flush=1:
  - Both entries are invalidated and ctrl/data are zeroed; next state EMPTY; in_ready=1 next cycle.
  - An in-xfer in the same cycle is discarded.
  - An out-xfer in the same cycle still counts as consumed by downstream.
- Stall: out_ready=0 holds out_ctrl/out_data bit-stable while out_valid=1.
- in_ready depends only on registered state; no combinational path from out_ready to in_ready.
- Reset mid-operation: all entries lost immediately; no partial outputs.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined: adds output ports bubble_cnt[CNT_W] and flush_cnt[CNT_W], both reset to 0 by rst_n.
  - bubble_cnt increments each cycle out_valid=0.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at all-ones; no wrap.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan (DATA_W=32, CTRL_W=8):
- Reset then in_valid=1, in_ctrl=8'h5A, in_data=32'h0000_1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=8'h5A, out_data=32'h1234; prior cycle out_ctrl=0.
- out_ready=0, push A=1, B=2, C=3 on consecutive cycles -> A and B accepted, in_ready=0 after B, C held upstream. Release out_ready -> outputs 1,2,3 in order, no gaps beyond one.
- State TWO, flush=1 with in_valid=1 (data 7) -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; data 7 never appears.
- Continuous stream 0..99 with out_ready toggled pseudo-randomly -> scoreboard receives 0..99 exactly once, in order, with out_ctrl=0 whenever out_valid=0.
- rst_n pulsed low mid-cycle while in state TWO -> out_valid, out_ctrl, out_data fall to 0 immediately and in_ready=1 before the next edge.
- PIPE_STATS_EN, CNT_W=4: 20 idle cycles and 3 flush pulses -> bubble_cnt=4'hF (saturated), flush_cnt=3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised valid/ready pipeline stage register carrying one
//               opaque control bundle and one opaque data bundle per
//               instruction. A 2-entry arrangement (main + skid) gives full
//               throughput while in_ready is driven from registered state
//               only. Synchronous flush collapses the stage to a zero-control
//               bubble; rst_n clears everything asynchronously.
// Options     : `define PIPE_STATS_EN adds saturating bubble_cnt / flush_cnt
//               statistics outputs.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - upstream presents an instruction
//               in_ready   - stage can accept (registered, = !skid valid)
//               in_ctrl    - upstream control bundle (all-zero = no-op)
//               in_data    - upstream data bundle
//               flush      - synchronous kill of all held entries
//               out_valid  - main entry holds a live instruction
//               out_ready  - downstream accepts (low = stall)
//               out_ctrl   - registered control, zero while out_valid=0
//               out_data   - registered data, zero while out_valid=0
//               bubble_cnt - (PIPE_STATS_EN) cycles with out_valid=0
//               flush_cnt  - (PIPE_STATS_EN) cycles with flush=1
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Occupancy: EMPTY (nothing held), ONE (main valid), TWO (main + skid).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e             state_q;
  logic [CTRL_W-1:0]  main_ctrl_q;
  logic [DATA_W-1:0]  main_data_q;
  logic [CTRL_W-1:0]  skid_ctrl_q;
  logic [DATA_W-1:0]  skid_data_q;

  // Both handshake outputs decode registered state only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q == S_ONE) || (state_q == S_TWO);

  // Main payload registers are kept at zero whenever the entry is invalid,
  // so the outputs are zero during bubbles without extra gating.
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      // Any same-cycle input is discarded; a same-cycle output transfer has
      // already been consumed downstream, so dropping everything is correct.
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      // in_ready is 1 in EMPTY/ONE and out_valid is 1 in ONE/TWO, so the raw
      // valid/ready inputs stand for the transfers in each branch below.
      case (state_q)
        S_EMPTY: begin
          if (in_valid) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= S_ONE;
          end
        end

        S_ONE: begin
          if (in_valid && out_ready) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (in_valid) begin
            // Downstream stalled: park the newcomer behind the main entry.
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            state_q     <= S_TWO;
          end else if (out_ready) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            state_q     <= S_EMPTY;
          end
        end

        S_TWO: begin
          if (out_ready) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            state_q     <= S_ONE;
          end
        end

        default: begin
          state_q     <= S_EMPTY;
          main_ctrl_q <= '0;
          main_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STATS_EN
  // Saturating statistics counters; they stick at all-ones instead of
  // wrapping so a long-running count never reads as small.
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  // CNT_W only sizes the statistics counters, which are absent here.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (DATA_W=32, CTRL_W=8).
//               Directed vector table plus hand-written sequences for the
//               stalled stream, asynchronous reset and statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data)
`ifdef PIPE_STATS_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs applied before an edge, outputs expected just after it.
  typedef struct packed {
    logic              iv;
    logic [CTRL_W-1:0] ic;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              fl;
    logic              e_ov;
    logic              e_ir;
    logic [CTRL_W-1:0] e_oc;
    logic [DATA_W-1:0] e_od;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("reset_out_data",  out_data,       32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int rcvd;
    int cycles;
    logic              stalled;
    logic [DATA_W-1:0] held_data;
    logic [CTRL_W-1:0] held_ctrl;

    //           iv    ic     id      ordy  fl    ov    ir    oc     od
    vecs[0]  = '{1'b1, 8'h5A, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 32'h1234};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[2]  = '{1'b1, 8'h01, 32'h1,    1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 32'h1};
    vecs[3]  = '{1'b1, 8'h02, 32'h2,    1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 32'h1};
    vecs[4]  = '{1'b1, 8'h03, 32'h3,    1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 32'h1};
    vecs[5]  = '{1'b1, 8'h03, 32'h3,    1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h2};
    vecs[6]  = '{1'b1, 8'h03, 32'h3,    1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 32'h3};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[8]  = '{1'b1, 8'h11, 32'h5,    1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 32'h5};
    vecs[9]  = '{1'b1, 8'h22, 32'h6,    1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 32'h5};
    vecs[10] = '{1'b1, 8'h77, 32'h7,    1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[11] = '{1'b0, 8'h00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[12] = '{1'b1, 8'h33, 32'h8,    1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[13] = '{1'b1, 8'h44, 32'h9,    1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 32'h9};
    vecs[14] = '{1'b0, 8'h00, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 32'h9};
    vecs[15] = '{1'b0, 8'h00, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0};

    do_reset();

    // ---------------- directed vector table ----------------
    for (int i = 0; i < NVEC; i++) begin
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ic;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_ctrl", i),  32'(out_ctrl),  32'(vecs[i].e_oc));
      chk($sformatf("v%0d_out_data", i),  out_data,       vecs[i].e_od);
    end

    // ---------------- stream 0..99 with random back-pressure ----------------
    do_reset();
    sent    = 0;
    rcvd    = 0;
    cycles  = 0;
    stalled = 1'b0;
    held_data = '0;
    held_ctrl = '0;
    while (rcvd < 100 && cycles < 2000) begin
      if (!out_valid) begin
        chk("stream_bubble_ctrl", 32'(out_ctrl), 32'd0);
        chk("stream_bubble_data", out_data, 32'd0);
      end
      if (stalled) begin
        chk("stream_stall_ctrl", 32'(out_ctrl), 32'(held_ctrl));
        chk("stream_stall_data", out_data, held_data);
      end
      in_valid  = (sent < 100);
      in_data   = 32'(sent);
      in_ctrl   = 8'(sent + 1);
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'b0;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("stream_order_data", out_data, 32'(rcvd));
        chk("stream_order_ctrl", 32'(out_ctrl), 32'(8'(rcvd + 1)));
        rcvd++;
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_ctrl = out_ctrl;
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("stream_received_count", 32'(rcvd), 32'd100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stream_no_extra", 32'(out_valid), 32'd0);
    end

    // ---------------- asynchronous reset while holding two ----------------
    do_reset();
    in_valid  = 1'b1;
    in_ctrl   = 8'hA1;
    in_data   = 32'hA1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_ctrl = 8'hA2;
    in_data = 32'hA2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("areset_pre_in_ready",  32'(in_ready),  32'd0);
    chk("areset_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    chk("areset_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("areset_out_data",  out_data,       32'd0);
    chk("areset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("areset_after_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    repeat (20) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("stats_bubble_cnt", 32'(bubble_cnt), 32'hF);
    chk("stats_flush_cnt",  32'(flush_cnt),  32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
